shared_mem_arbiter: RTL and testbench

Arbitrates one single-port data memory between the two CPU cores, then hands it to the VGA readout once both cores are done. During the run phase the cores share the memory round-robin. After both `done` flags are seen, a one-cycle drain lets any in-flight read complete, then the VGA reader gets exclusive access. It sits between the two `CPU` instances, the VGA scan logic and the data RAM.

---
 rtl/shared_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Shares one single-port data RAM between two CPU cores (round-robin) during RUN,
// then hands it exclusively to the VGA reader after a one-cycle drain.
module shared_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c0_req,
    input  logic              c1_req,
    input  logic              c0_we,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic [DATA_W-1:0] c1_wdata,
    input  logic              c0_done,
    input  logic              c1_done,
    output logic              c0_gnt,
    output logic              c1_gnt,
    output logic              c0_rvalid,
    output logic              c1_rvalid,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        phase,
    output logic              scan_active
);

    localparam logic [1:0] PH_RUN   = 2'd0;
    localparam logic [1:0] PH_DRAIN = 2'd1;
    localparam logic [1:0] PH_SCAN  = 2'd2;

    logic [1:0] phase_q, phase_d;
    logic       last_q, last_d;
    logic [1:0] done_q, done_d;
    logic       rd_pend_q, rd_pend_d;
    logic       owner_q, owner_d;
    logic       rd_vga_q, rd_vga_d;

    logic [1:0]        core_req;
    logic [1:0]        core_done;
    logic [1:0]        active;
    logic [1:0]        core_gnt;
    logic              vga_gnt_w;

    assign core_req  = {c1_req, c0_req};
    assign core_done = {c1_done, c0_done};

    // A core raising done in the same cycle as a request is already treated as finished.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_core
            assign active[gi] = core_req[gi] & ~done_q[gi] & ~core_done[gi];
            assign done_d[gi] = done_q[gi] | core_done[gi];
        end
    endgenerate

    always_comb begin
        core_gnt  = 2'b00;
        vga_gnt_w = 1'b0;
        last_d    = last_q;
        if (!reset) begin
            case (phase_q)
                PH_RUN: begin
                    if (active == 2'b11) begin
                        core_gnt = last_q ? 2'b01 : 2'b10;
                    end else begin
                        core_gnt = active;
                    end
                    if (core_gnt != 2'b00) begin
                        last_d = core_gnt[1];
                    end
                end
                PH_SCAN: begin
                    vga_gnt_w = vga_req;
                end
                default: begin
                    core_gnt  = 2'b00;
                    vga_gnt_w = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt[0]) begin
            mem_en    = 1'b1;
            mem_we    = c0_we;
            mem_addr  = c0_addr;
            mem_wdata = c0_wdata;
        end else if (core_gnt[1]) begin
            mem_en    = 1'b1;
            mem_we    = c1_we;
            mem_addr  = c1_addr;
            mem_wdata = c1_wdata;
        end else if (vga_gnt_w) begin
            mem_en    = 1'b1;
            mem_addr  = vga_addr;
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_RUN:   if (done_q == 2'b11) phase_d = PH_DRAIN;
            PH_DRAIN: phase_d = PH_SCAN;
            PH_SCAN:  phase_d = PH_SCAN;
            default:  phase_d = PH_RUN;
        endcase
    end

    // Read-return tracking: who owns the access in flight, and whether it was a read.
    always_comb begin
        rd_pend_d = mem_en & ~mem_we;
        owner_d   = core_gnt[1];
        rd_vga_d  = vga_gnt_w;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q   <= PH_RUN;
            last_q    <= 1'b1;
            done_q    <= 2'b00;
            rd_pend_q <= 1'b0;
            owner_q   <= 1'b0;
            rd_vga_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            last_q    <= last_d;
            done_q    <= done_d;
            rd_pend_q <= rd_pend_d;
            owner_q   <= owner_d;
            rd_vga_q  <= rd_vga_d;
        end
    end

    assign c0_gnt  = core_gnt[0];
    assign c1_gnt  = core_gnt[1];
    assign vga_gnt = vga_gnt_w;

    // Gating with reset lets a reset cycle cancel an rvalid that is already registered.
    assign c0_rvalid  = rd_pend_q & ~rd_vga_q & ~owner_q & ~reset;
    assign c1_rvalid  = rd_pend_q & ~rd_vga_q &  owner_q & ~reset;
    assign vga_rvalid = rd_pend_q &  rd_vga_q & ~reset;

    assign rdata       = mem_rdata;
    assign phase       = phase_q;
    assign scan_active = (phase_q == PH_SCAN);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a registered-read RAM model behind it.
module tb_shared_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        c0_req, c1_req, c0_we, c1_we;
    logic [15:0] c0_addr, c1_addr;
    logic [31:0] c0_wdata, c1_wdata;
    logic        c0_done, c1_done;
    logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_gnt, vga_rvalid;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  phase;
    logic        scan_active;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram [0:65535];

    always #5 clock = ~clock;

    // RAM model: preloads on reset, registered read one cycle after a read enable.
    always @(posedge clock) begin
        if (reset) begin
            ram[16'h0010] <= 32'hDEADBEEF;
            ram[16'h0011] <= 32'hCAFEF00D;
            mem_rdata     <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    shared_mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
        .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
        .c0_done(c0_done), .c1_done(c1_done),
        .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .phase(phase), .scan_active(scan_active)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0;
        c0_addr = 0; c1_addr = 0; c0_wdata = 0; c1_wdata = 0;
        c0_done = 0; c1_done = 0; vga_req = 0; vga_addr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        c0_req = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #2;
            checks++;
            if ({c0_gnt, c1_gnt, vga_gnt, c0_rvalid, c1_rvalid, vga_rvalid, mem_en, mem_we} !== 8'h00) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%b expected=00000000", i,
                         {c0_gnt, c1_gnt, vga_gnt, c0_rvalid, c1_rvalid, vga_rvalid, mem_en, mem_we});
            end
            checks++;
            if (phase !== 2'd0 || scan_active !== 1'b0) begin
                failures++;
                $display("FAIL reset_phase got phase=%0d scan=%b expected phase=0 scan=0", phase, scan_active);
            end
        end
        tick();
        reset = 0;
        c0_req = 1; c0_we = 0; c0_addr = 16'h0010;
        #2;
        checks++;
        if (c0_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
            failures++;
            $display("FAIL single_read_grant got gnt=%b en=%b we=%b addr=%h expected gnt=1 en=1 we=0 addr=0010",
                     c0_gnt, mem_en, mem_we, mem_addr);
        end
        tick();
        idle_inputs();
        #2;
        checks++;
        if (c0_rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_read_data got rvalid=%b rdata=%h expected rvalid=1 rdata=deadbeef", c0_rvalid, rdata);
        end
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL idle_bus got en=%b addr=%h wdata=%h expected 0 0 0", mem_en, mem_addr, mem_wdata);
        end
        $display("test_reset done");
    endtask

    task automatic test_contention();
        logic [31:0] exp_data [2];
        exp_data[0] = 32'hDEADBEEF;
        exp_data[1] = 32'hCAFEF00D;
        do_reset();
        c0_req = 1; c1_req = 1; c0_addr = 16'h0010; c1_addr = 16'h0011;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin c0_req = 0; c1_req = 0; end
            #2;
            if (k < 4) begin
                checks++;
                if (c0_gnt !== (k % 2 == 0) || c1_gnt !== (k % 2 == 1)) begin
                    failures++;
                    $display("FAIL contention_gnt cyc=%0d got g0=%b g1=%b expected core%0d", k, c0_gnt, c1_gnt, k % 2);
                end
            end
            if (k > 0) begin
                checks++;
                if (c0_rvalid !== ((k - 1) % 2 == 0) || c1_rvalid !== ((k - 1) % 2 == 1)
                    || rdata !== exp_data[(k - 1) % 2]) begin
                    failures++;
                    $display("FAIL contention_rvalid cyc=%0d got v0=%b v1=%b rdata=%h expected core%0d data=%h",
                             k, c0_rvalid, c1_rvalid, rdata, (k - 1) % 2, exp_data[(k - 1) % 2]);
                end
            end
            $display("contention cycle %0d g0=%b g1=%b v0=%b v1=%b", k, c0_gnt, c1_gnt, c0_rvalid, c1_rvalid);
            tick();
        end
    endtask

    task automatic test_write();
        idle_inputs();
        c1_req = 1; c1_we = 1; c1_addr = 16'h0020; c1_wdata = 32'h12345678;
        #2;
        checks++;
        if (c1_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0020
            || mem_wdata !== 32'h12345678) begin
            failures++;
            $display("FAIL write_issue got gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 0020 12345678",
                     c1_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        idle_inputs();
        c0_req = 1; c0_addr = 16'h0020;
        #2;
        checks++;
        if (c1_rvalid !== 1'b0 || c0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL write_no_rvalid got v0=%b v1=%b expected 0 0", c0_rvalid, c1_rvalid);
        end
        tick();
        idle_inputs();
        #2;
        checks++;
        if (c0_rvalid !== 1'b1 || rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL write_readback got rvalid=%b rdata=%h expected 1 12345678", c0_rvalid, rdata);
        end
        $display("test_write done");
        tick();
    endtask

    task automatic test_phase_change();
        logic [1:0] exp_phase;
        logic       exp_vga;
        do_reset();
        vga_addr = 16'h0010;
        for (int cyc = 0; cyc <= 13; cyc++) begin
            vga_req = (cyc >= 3);
            c0_done = (cyc == 5);
            c1_done = (cyc == 9);
            c1_req  = (cyc == 9);
            c0_req  = (cyc == 12);
            exp_phase = (cyc <= 10) ? 2'd0 : (cyc == 11) ? 2'd1 : 2'd2;
            exp_vga   = (cyc >= 12);
            #2;
            checks++;
            if (phase !== exp_phase || vga_gnt !== exp_vga || scan_active !== (exp_phase == 2'd2)) begin
                failures++;
                $display("FAIL phase_seq cyc=%0d got phase=%0d vga_gnt=%b scan=%b expected %0d %b %b",
                         cyc, phase, vga_gnt, scan_active, exp_phase, exp_vga, exp_phase == 2'd2);
            end
            if (cyc == 9) begin
                checks++;
                if (c1_gnt !== 1'b0) begin
                    failures++;
                    $display("FAIL done_with_req got c1_gnt=%b expected 0", c1_gnt);
                end
            end
            if (cyc == 12) begin
                checks++;
                if (c0_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
                    failures++;
                    $display("FAIL scan_exclusive got c0_gnt=%b we=%b addr=%h expected 0 0 0010",
                             c0_gnt, mem_we, mem_addr);
                end
            end
            if (cyc == 13) begin
                checks++;
                if (vga_rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || c0_rvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL vga_read got vrvalid=%b rdata=%h v0=%b expected 1 deadbeef 0",
                             vga_rvalid, rdata, c0_rvalid);
                end
            end
            $display("phase cycle %0d phase=%0d vga_gnt=%b", cyc, phase, vga_gnt);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_finished_core();
        do_reset();
        c0_done = 1;
        tick();
        c0_done = 0;
        c0_req = 1; c1_req = 1; c1_addr = 16'h0011;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++;
            if (c0_gnt !== 1'b0 || c1_gnt !== 1'b1) begin
                failures++;
                $display("FAIL finished_core cyc=%0d got g0=%b g1=%b expected 0 1", k, c0_gnt, c1_gnt);
            end
            $display("finished_core cycle %0d g0=%b g1=%b", k, c0_gnt, c1_gnt);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        c1_req = 1; c1_addr = 16'h0011;
        tick();
        idle_inputs();
        c0_req = 1; c0_addr = 16'h0010;
        #2;
        checks++;
        if (c0_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midread_grant got c0_gnt=%b expected 1", c0_gnt);
        end
        tick();
        idle_inputs();
        reset = 1;
        #2;
        checks++;
        if (c0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL midread_cancel got c0_rvalid=%b expected 0", c0_rvalid);
        end
        tick();
        reset = 0;
        #2;
        checks++;
        if (phase !== 2'd0 || c0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL midread_after got phase=%0d rvalid=%b expected 0 0", phase, c0_rvalid);
        end
        c0_req = 1; c1_req = 1; c0_addr = 16'h0010; c1_addr = 16'h0011;
        #1;
        checks++;
        if (c0_gnt !== 1'b1 || c1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL midread_tie got g0=%b g1=%b expected 1 0", c0_gnt, c1_gnt);
        end
        $display("test_reset_mid_read done");
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_contention();
        test_write();
        test_phase_change();
        test_finished_core();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
